// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch front end. Owns the fetch PC, issues word requests to instruction memory
//   over a req/gnt/rvalid interface, tags each granted request with its PC in an in-order tag
//   queue, and buffers returned words with their PCs for the decode stage. Taken-branch/jal
//   redirects flush buffered and in-flight wrong-path work; responses to requests already
//   granted before a redirect are counted down and dropped (DRAIN state).
//
//   Ports
//     clk, rst          clock; synchronous active-high reset
//     imem_req/addr     request valid and word address toward instruction memory
//     imem_gnt          request accepted when imem_req & imem_gnt
//     imem_rvalid/rdata in-order read response
//     redirect/_pc      one-cycle taken-branch pulse and target (bits[1:0] ignored)
//     instr_valid/instr/instr_pc  registered buffer head toward decode
//     dec_ready         decode accepts head when instr_valid & dec_ready
//     instr_illegal     head opcode unsupported
//
//   Optional feature: define FETCH_ILLEGAL_CHK_EN to enable the opcode checker; otherwise
//   instr_illegal is tied low.
// ---------------------------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        dec_ready,
    output logic        instr_illegal
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SumW = CntW + 1;

    typedef enum logic [0:0] {StFetch, StDrain} state_e;

    state_e            state_q;
    logic [31:0]       fetch_pc_q;
    logic [CntW-1:0]   inflight_q;
    logic [CntW-1:0]   discard_q;

    // In-order PC tags of granted requests
    logic [31:0]       tag_pc_q [FIFO_DEPTH];
    logic [PtrW-1:0]   tag_wr_q;
    logic [PtrW-1:0]   tag_rd_q;

    // Instruction buffer
    logic [31:0]       buf_data_q [FIFO_DEPTH];
    logic [31:0]       buf_pc_q   [FIFO_DEPTH];
    logic [PtrW-1:0]   buf_wr_q;
    logic [PtrW-1:0]   buf_rd_q;
    logic [CntW-1:0]   buf_cnt_q;

    logic              credit_ok;
    logic              grant;
    logic              rsp;
    logic              rsp_keep;
    logic              pop;
    logic              buf_valid;
    logic [31:0]       redirect_pc_aligned;
    logic [CntW-1:0]   discard_redir;
    logic [CntW-1:0]   discard_dec;

    assign redirect_pc_aligned = redirect_pc & ~32'd3;

    always_comb begin
        // Occupancy plus in-flight never exceeds depth, so every granted response has a slot.
        // Neither term can grow while a request waits for grant, so imem_req stays asserted.
        credit_ok = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < SumW'(FIFO_DEPTH);
        imem_req  = !rst && (state_q == StFetch) && !redirect && credit_ok;
        grant     = imem_req && imem_gnt;
        rsp       = !rst && imem_rvalid;
        // A response is kept only if it belongs to the current path
        rsp_keep  = rsp && (discard_q == '0);
        buf_valid = (buf_cnt_q != '0);
        pop       = !rst && buf_valid && dec_ready;
        // Everything in flight at a redirect is wrong-path, except a response landing right now
        discard_redir = inflight_q - CntW'(rsp);
        discard_dec   = (rsp && (discard_q != '0)) ? discard_q - CntW'(1) : discard_q;
    end

    assign imem_addr = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            buf_wr_q   <= '0;
            buf_rd_q   <= '0;
            buf_cnt_q  <= '0;
        end else begin
            inflight_q <= inflight_q + CntW'(grant) - CntW'(rsp);

            if (grant) begin
                tag_pc_q[tag_wr_q] <= fetch_pc_q;
                tag_wr_q           <= tag_wr_q + PtrW'(1);
            end

            if (redirect) begin
                // No grant is possible this cycle, so tag_wr_q is stable here
                fetch_pc_q <= redirect_pc_aligned;
                discard_q  <= discard_redir;
                state_q    <= (discard_redir != '0) ? StDrain : StFetch;
                tag_rd_q   <= tag_wr_q;
                buf_wr_q   <= '0;
                buf_rd_q   <= '0;
                buf_cnt_q  <= '0;
            end else begin
                if (grant) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                discard_q <= discard_dec;

                unique case (state_q)
                    StFetch: state_q <= StFetch;
                    StDrain: state_q <= (discard_dec == '0) ? StFetch : StDrain;
                    default: state_q <= StFetch;
                endcase

                if (rsp_keep) begin
                    buf_data_q[buf_wr_q] <= imem_rdata;
                    buf_pc_q[buf_wr_q]   <= tag_pc_q[tag_rd_q];
                    buf_wr_q             <= buf_wr_q + PtrW'(1);
                    tag_rd_q             <= tag_rd_q + PtrW'(1);
                end
                if (pop) begin
                    buf_rd_q <= buf_rd_q + PtrW'(1);
                end
                buf_cnt_q <= buf_cnt_q + CntW'(rsp_keep) - CntW'(pop);
            end
        end
    end

    // Head is presented straight from registers; no path from imem_rdata
    assign instr_valid = !rst && buf_valid;
    assign instr       = instr_valid ? buf_data_q[buf_rd_q] : 32'd0;
    assign instr_pc    = instr_valid ? buf_pc_q[buf_rd_q]   : 32'd0;

`ifdef FETCH_ILLEGAL_CHK_EN
    logic op_ok;

    always_comb begin
        op_ok = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b0100011, 7'b0110011,
            7'b1100011, 7'b0010011, 7'b1101111: op_ok = 1'b1;
            default:                            op_ok = 1'b0;
        endcase
    end

    assign instr_illegal = instr_valid & ((instr[1:0] != 2'b11) | !op_ok);
`else
    assign instr_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. A small instruction-memory responder with configurable
//   latency drives the DUT; a queue-based model (outstanding memory requests, buffered PCs,
//   pending wrong-path responses, next fetch PC) predicts the outputs every cycle. Literal
//   checks pin key cycle-exact points of the model.
// ---------------------------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned FD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_ILLEGAL_CHK_EN
    localparam logic EXP_LUI_ILL = 1'b1;
`else
    localparam logic EXP_LUI_ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        dec_ready;
    logic        instr_illegal;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .dec_ready     (dec_ready),
        .instr_illegal (instr_illegal)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          lat   = 1;

    // Model state
    pend_t       pend[$];
    logic [31:0] mbuf[$];
    int          wrong = 0;
    logic [31:0] exp_fpc = RPC;

    // Observations of the most recent cycle
    logic        obs_req, obs_grant, obs_valid, obs_ill;
    logic [31:0] obs_addr, obs_pc;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        if (pc == 32'h0000_0300) return 32'h0000_0037;
        if (pc == 32'h0000_0304) return 32'h0000_0013;
        return {pc[26:2] ^ 25'h15A_5A5A, 7'b0010011};
    endfunction

    function automatic logic exp_ill(input logic v, input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHK_EN
        logic ok;
        ok = (w[1:0] == 2'b11) && (w[6:0] inside {7'b0000011, 7'b0100011, 7'b0110011,
                                                   7'b1100011, 7'b0010011, 7'b1101111});
        return v && !ok;
`else
        return 1'b0 & v & w[0];
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_req, e_v;
        logic [31:0] hpc;
        if (rst) begin
            chk("rst_imem_req", imem_req, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_instr", instr, 0);
            chk("rst_instr_pc", instr_pc, 0);
            chk("rst_instr_illegal", instr_illegal, 0);
        end else begin
            e_req = !redirect && (wrong == 0) && (pend.size() + mbuf.size() < FD);
            chk("imem_req", imem_req, e_req);
            if (e_req && imem_req) chk("imem_addr", imem_addr, exp_fpc);
            e_v = (mbuf.size() > 0);
            chk("instr_valid", instr_valid, e_v);
            hpc = e_v ? mbuf[0] : 32'd0;
            if (e_v && instr_valid) begin
                chk("instr_pc", instr_pc, hpc);
                chk("instr", instr, word_of(hpc));
            end
            chk("instr_illegal", instr_illegal, exp_ill(e_v, word_of(hpc)));
        end
    endtask

    task automatic step();
        logic        s_rst, s_grant, s_rv, s_pop, s_redir;
        logic [31:0] s_addr, s_rpc, rpc;
        pend_t       e;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        check_outputs();
        s_rst     = rst;
        s_grant   = imem_req && imem_gnt;
        s_addr    = imem_addr;
        s_rv      = imem_rvalid;
        s_pop     = instr_valid && dec_ready;
        s_redir   = redirect;
        s_rpc     = redirect_pc;
        obs_req   = imem_req;
        obs_grant = s_grant;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_ill   = instr_illegal;
        @(posedge clk);
        if (s_rst) begin
            pend.delete();
            mbuf.delete();
            wrong   = 0;
            exp_fpc = RPC;
        end else begin
            rpc = 32'd0;
            if (s_rv) begin
                e   = pend.pop_front();
                rpc = e.addr;
            end
            if (s_grant) begin
                e.addr = s_addr;
                e.due  = cyc + lat;
                pend.push_back(e);
                exp_fpc = exp_fpc + 32'd4;
            end
            if (s_redir) begin
                mbuf.delete();
                wrong   = pend.size();
                exp_fpc = s_rpc & ~32'd3;
            end else begin
                if (s_pop) void'(mbuf.pop_front());
                if (s_rv) begin
                    if (wrong > 0) wrong--;
                    else mbuf.push_back(rpc);
                end
            end
        end
        cyc++;
        #1;
        redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string nm, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!obs_grant && n < 50);
        chk(nm, obs_grant, 1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!obs_valid && n < 50);
        chk(nm, obs_valid, 1);
    endtask

    initial begin
        int n;
        int grants;
        logic found;
        rst         = 1'b1;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        dec_ready   = 1'b1;

        // 1: reset release, streaming, plus a grant stall
        do_reset();
        step();
        chk("t1_c0_grant", obs_grant, 1);
        chk("t1_c0_addr", obs_addr, 32'h0);
        chk("t1_c0_valid", obs_valid, 0);
        step();
        chk("t1_c1_grant", obs_grant, 1);
        chk("t1_c1_addr", obs_addr, 32'h4);
        chk("t1_c1_valid", obs_valid, 0);
        step();
        chk("t1_c2_valid", obs_valid, 1);
        chk("t1_c2_pc", obs_pc, 32'h0);
        step();
        chk("t1_c3_valid", obs_valid, 1);
        chk("t1_c3_pc", obs_pc, 32'h4);
        for (int i = 0; i < 6; i++) step();
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) step();
        imem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // 2: decode stalled from reset
        do_reset();
        dec_ready = 1'b0;
        grants    = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_grant) grants++;
        end
        chk("t2_grants", grants, FD);
        chk("t2_req_off", obs_req, 0);
        chk("t2_head_valid", obs_valid, 1);
        chk("t2_head_pc", obs_pc, 32'h0);
        dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // 3: redirect with two requests in flight
        do_reset();
        lat = 3;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        chk("t3_req_in_r", obs_req, 0);
        wait_grant("t3_grant_seen", n);
        chk("t3_grant_delay", n, 3);
        chk("t3_addr", obs_addr, 32'h100);
        wait_valid("t3_valid_seen");
        chk("t3_first_pc", obs_pc, 32'h100);
        lat = 1;
        for (int i = 0; i < 4; i++) step();

        // 4: PC wrap and misaligned redirect target
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (obs_grant && obs_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        chk("t4_fffc_seen", found, 1);
        wait_grant("t4_wrap_grant", n);
        chk("t4_wrap_addr", obs_addr, 32'h0);
        for (int i = 0; i < 3; i++) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        wait_grant("t4_al_grant", n);
        chk("t4_al_addr", obs_addr, 32'h200);
        wait_valid("t4_al_valid");
        chk("t4_al_pc", obs_pc, 32'h200);

        // 5: reset with a full buffer
        dec_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t5_full_valid", obs_valid, 1);
        chk("t5_full_req", obs_req, 0);
        rst = 1'b1;
        step();
        chk("t5_rst_valid", obs_valid, 0);
        chk("t5_rst_req", obs_req, 0);
        rst       = 1'b0;
        dec_ready = 1'b1;
        step();
        chk("t5_rel_grant", obs_grant, 1);
        chk("t5_rel_addr", obs_addr, RPC);
        chk("t5_rel_valid", obs_valid, 0);
        for (int i = 0; i < 4; i++) step();

        // 6: illegal-opcode flag on lui, clear on addi
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        wait_valid("t6_lui_valid");
        chk("t6_lui_pc", obs_pc, 32'h300);
        chk("t6_lui_ill", obs_ill, EXP_LUI_ILL);
        wait_valid("t6_addi_valid");
        chk("t6_addi_pc", obs_pc, 32'h304);
        chk("t6_addi_ill", obs_ill, 0);
        for (int i = 0; i < 4; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
